// File: rtl/norm_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : norm_shift_ctrl
// Purpose  : Sequences the two normalising operand shift registers of the
//            approximate multiplier and reports the combined shift count.
// Revision : 1.0 - initial release
// ============================================================================
module norm_shift_ctrl #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic             load_a,
    output logic             load_b,
    output logic             shift_a,
    output logic             shift_b,
    output logic             store_a,
    output logic             store_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W:0]   shift_sum,
    output logic             zero_result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_NORM  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH - 1);

    generate
        if ((2 ** CNT_W) < WIDTH || OUT_WIDTH > WIDTH) begin : g_param_check
            $error("norm_shift_ctrl: CNT_W too small or OUT_WIDTH exceeds WIDTH");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_zero;
    logic             w_in_norm;
    logic             w_shift_a;
    logic             w_shift_b;

    // The counter cap also bounds NORM if a_zero/b_zero is ever mis-driven.
    assign w_in_norm = (r_state == S_NORM);
    assign w_shift_a = w_in_norm && !a_msb && !a_zero && (r_cnt_a != C_CNT_MAX);
    assign w_shift_b = w_in_norm && !b_msb && !b_zero && (r_cnt_b != C_CNT_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_NORM;
            S_NORM:  if (!w_shift_a && !w_shift_b) w_next = S_STORE;
            S_STORE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD) begin
                r_cnt_a <= '0;
                r_cnt_b <= '0;
                r_zero  <= 1'b0;
            end else if (w_in_norm) begin
                if (w_shift_a) r_cnt_a <= r_cnt_a + 1'b1;
                if (w_shift_b) r_cnt_b <= r_cnt_b + 1'b1;
                if (!w_shift_a && !w_shift_b) r_zero <= a_zero | b_zero;
            end
        end
    end

    assign load_a      = (r_state == S_LOAD);
    assign load_b      = (r_state == S_LOAD);
    assign shift_a     = w_shift_a;
    assign shift_b     = w_shift_b;
    assign store_a     = (r_state == S_STORE);
    assign store_b     = (r_state == S_STORE);
    assign done        = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign cnt_a       = r_cnt_a;
    assign cnt_b       = r_cnt_b;
    assign shift_sum   = {1'b0, r_cnt_a} + {1'b0, r_cnt_b};
    assign zero_result = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_norm_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_shift_ctrl
// Purpose  : Scoreboard bench for norm_shift_ctrl with operand shift-register
//            models and a leading-zero reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        a_msb, b_msb, a_zero, b_zero;
    logic        load_a, load_b, shift_a, shift_b, store_a, store_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [4:0]  shift_sum;
    logic        zero_result, busy, done;

    logic [15:0] op_a = 16'h0, op_b = 16'h0;
    logic [15:0] r_reg_a = 16'h0, r_reg_b = 16'h0;
    logic        force_a = 1'b0;
    int          ncyc = 0;
    int          total = 0;
    int          bad = 0;
    int          next_free = 0;
    int          sa = 0, sb = 0, st_cyc = -10;

    typedef struct {
        int ca;
        int cb;
        int zr;
        int at;
    } exp_t;
    exp_t q[$];

    norm_shift_ctrl #(.WIDTH(16), .OUT_WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_msb(a_msb), .b_msb(b_msb), .a_zero(a_zero), .b_zero(b_zero),
        .load_a(load_a), .load_b(load_b), .shift_a(shift_a), .shift_b(shift_b),
        .store_a(store_a), .store_b(store_b), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .shift_sum(shift_sum), .zero_result(zero_result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Datapath shift registers driven by the controller's strobes.
    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        if (load_a) r_reg_a <= op_a; else if (shift_a) r_reg_a <= r_reg_a << 1;
        if (load_b) r_reg_b <= op_b; else if (shift_b) r_reg_b <= r_reg_b << 1;
    end
    assign a_msb  = force_a ? 1'b0 : r_reg_a[15];
    assign a_zero = force_a ? 1'b0 : (r_reg_a == 16'h0);
    assign b_msb  = r_reg_b[15];
    assign b_zero = (r_reg_b == 16'h0);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    function automatic int lz(input logic [15:0] x);
        if (x == 16'h0) return 0;
        for (int i = 15; i >= 0; i--) if (x[i]) return 15 - i;
        return 0;
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input bit frc, input int n);
        exp_t e;
        int m;
        e.ca = frc ? 15 : lz(a);
        e.cb = lz(b);
        e.zr = ((!frc && a == 16'h0) || b == 16'h0) ? 1 : 0;
        m    = (e.ca > e.cb) ? e.ca : e.cb;
        e.at = n + 4 + m;
        return e;
    endfunction

    task automatic wait_until(input int target);
        while (ncyc < target) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input bit frc, output int done_at);
        exp_t e;
        wait_until(next_free);
        op_a = a; op_b = b; force_a = frc;
        start = 1'b1;
        e = model(a, b, frc, ncyc);
        q.push_back(e);
        done_at = e.at;
        next_free = e.at + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_at(input int when);
        wait_until(when);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic held(input logic [15:0] a, input logic [15:0] b, input int k);
        exp_t e;
        int n0, per;
        wait_until(next_free);
        op_a = a; op_b = b; force_a = 1'b0;
        n0 = ncyc;
        e = model(a, b, 1'b0, n0);
        per = e.at - n0 + 1;
        for (int i = 0; i < k; i++) begin
            e = model(a, b, 1'b0, n0 + i * per);
            q.push_back(e);
        end
        start = 1'b1;
        wait_until(n0 + (k - 1) * per + 2);
        start = 1'b0;
        next_free = n0 + k * per;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("strobe_exclusive",
                int'((shift_a | shift_b) & (load_a | load_b | store_a | store_b)), 0);
            if (load_a) sa = 0;
            if (load_b) sb = 0;
            if (shift_a) sa++;
            if (shift_b) sb++;
            if (store_a && store_b) st_cyc = ncyc;
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("cnt_a", int'(cnt_a), e.ca);
                    chk("cnt_b", int'(cnt_b), e.cb);
                    chk("shift_sum", int'(shift_sum), e.ca + e.cb);
                    chk("zero_result", int'(zero_result), e.zr);
                    chk("done_cycle", ncyc, e.at);
                    chk("shift_a_pulses", sa, e.ca);
                    chk("shift_b_pulses", sb, e.cb);
                    chk("store_before_done", st_cyc, ncyc - 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, n, lza, lzb;
        logic [15:0] ra, rb;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt_a", int'(cnt_a), 0);
        chk("rst_cnt_b", int'(cnt_b), 0);
        chk("rst_zero", int'(zero_result), 0);
        chk("rst_strobes", int'({load_a, load_b, shift_a, shift_b, store_a, store_b}), 0);
        rst = 1'b0;
        next_free = ncyc + 1;

        issue(16'h8000, 16'h8000, 1'b0, d);
        issue(16'h0001, 16'h00F0, 1'b0, d);
        issue(16'h0000, 16'h0300, 1'b0, d);

        // Reset on the fifth NORM cycle of a long operation.
        issue(16'h0001, 16'h0001, 1'b0, d);
        n = d - 19;
        wait_until(n + 6);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cnt_a", int'(cnt_a), 0);
        chk("midrst_cnt_b", int'(cnt_b), 0);
        chk("midrst_store", int'(store_a | store_b), 0);
        rst = 1'b0;
        next_free = ncyc + 1;
        issue(16'h0001, 16'h0001, 1'b0, d);

        // Extra start pulses while busy must be ignored.
        issue(16'h0010, 16'h0400, 1'b0, d);
        pulse_at(d - 2);
        pulse_at(d);

        held(16'h4000, 16'h4000, 4);

        issue(16'h1234, 16'h8000, 1'b1, d);

        for (int i = 0; i < 40; i++) begin
            lza = $urandom_range(0, 16);
            lzb = $urandom_range(0, 16);
            ra = (lza == 16) ? 16'h0 : ((16'h8000 >> lza) | (16'($urandom) & ((16'h8000 >> lza) - 16'h1)));
            rb = (lzb == 16) ? 16'h0 : ((16'h8000 >> lzb) | (16'($urandom) & ((16'h8000 >> lzb) - 16'h1)));
            next_free = next_free + int'($urandom_range(0, 2));
            issue(ra, rb, 1'b0, d);
            if ($urandom_range(0, 3) == 0) pulse_at(d);
        end

        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/norm_shift_ctrl.md
Name: norm_shift_ctrl

Overview:
- Controller that sequences two 16-bit normalising shift registers (operand A and operand B) for the approximate multiplier.
- On start, it loads both registers and shifts each left until its MSB is 1, counting shifts per operand.
- It then strobes capture of each register's top 8 bits and reports the combined shift count for product re-alignment.
- Sits between the top-level multiplier FSM (start/done) and the two shift-register datapath instances.

Parameters:
WIDTH, 16, operand width held in each shift register
OUT_WIDTH, 8, truncated width captured on store (informational; sets shift_sum meaning)
CNT_W, 4, shift-counter width, must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request one normalisation; sampled only in IDLE
a_msb  input  1  bit WIDTH-1 of shift register A
b_msb  input  1  bit WIDTH-1 of shift register B
a_zero  input  1  register A contents are all zero
b_zero  input  1  register B contents are all zero
load_a  output  1  load enable for register A
load_b  output  1  load enable for register B
shift_a  output  1  shift-left-by-1 enable for register A
shift_b  output  1  shift-left-by-1 enable for register B
store_a  output  1  capture top OUT_WIDTH bits of A
store_b  output  1  capture top OUT_WIDTH bits of B
cnt_a  output  CNT_W  shifts applied to A in the current or last operation
cnt_b  output  CNT_W  shifts applied to B in the current or last operation
shift_sum  output  CNT_W+1  cnt_a + cnt_b, zero-extended, no overflow
zero_result  output  1  either operand was zero; product must be forced to 0
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All strobes, busy and done go to 0.
  - cnt_a, cnt_b and zero_result clear to 0.
  - Reset overrides any state, including mid-operation, with no completion pulse.
- States are IDLE, LOAD, NORM, STORE and DONE. All strobe outputs are decoded from the current state and registered counters.
- IDLE:
  - All strobes are 0.
  - If start=1, the next state is LOAD. Otherwise the FSM stays in IDLE.
- LOAD:
  - load_a=load_b=1 for exactly one cycle.
  - cnt_a and cnt_b clear at the end of the cycle.
  - Next state is NORM.
- NORM:
  - a_msb, a_zero, b_msb and b_zero are valid from the first NORM cycle.
  - shift_a = !a_msb && !a_zero && (cnt_a != WIDTH-1). shift_b follows the same rule with the B inputs.
  - Each counter increments on every edge where its shift strobe is high.
  - When shift_a=0 and shift_b=0 in the same cycle, the next state is STORE and zero_result is registered as a_zero|b_zero.
  - The operands finish independently. An operand that is already normalised holds while the other continues.
  - NORM lasts max(ka,kb)+1 cycles, where k is the leading-zero count of the operand (0 for a zero operand).
- STORE:
  - store_a=store_b=1 for one cycle.
  - Next state is DONE.
- DONE:
  - done=1 for one cycle.
  - Next state is IDLE, unconditionally.
- Latency from the start-sampling edge to done high is 4+max(ka,kb) cycles. Minimum is 4; maximum is 19 for WIDTH=16.
- start is ignored in LOAD, NORM, STORE and DONE, so no queuing occurs.
- If start is held high, a new operation begins on the IDLE cycle following DONE.
- The earliest back-to-back period is therefore 5+max(ka,kb) cycles.
- cnt_a, cnt_b, shift_sum and zero_result hold their final values after DONE until the next LOAD.
- The cnt cap at WIDTH-1 is a safety bound. It also stops shifting if a_zero is mis-driven, which prevents a hang.
- shift and load are never asserted in the same cycle. store is never asserted together with shift.

Test Plan:
- Normalised operands, no shifts: A=0x8000, B=0x8000, pulse start.
  - Response: load in cycle 1 and NORM for 1 cycle.
  - done at cycle 4 with cnt_a=0, cnt_b=0, shift_sum=0, zero_result=0.
  - shift_a and shift_b are never high.
- Unequal shift counts: A=0x0001, B=0x00F0.
  - Response: shift_a high for 15 consecutive cycles; shift_b high for the first 8 NORM cycles, then low.
  - done at cycle 19 with cnt_a=15, cnt_b=8, shift_sum=23.
- Zero operand: A=0x0000, B=0x0300.
  - Response: shift_a never asserted and cnt_a=0; cnt_b=6.
  - zero_result=1 and done at cycle 10.
- Reset mid-operation: A=0x0001, B=0x0001, assert rst on the 5th NORM cycle.
  - Response: next cycle is IDLE with busy=0, done=0, cnt_a=cnt_b=0 and no store or done pulse.
  - A fresh start then completes normally with cnt_a=cnt_b=15.
- Start during busy, and start held high:
  - Pulse start again during NORM and during DONE.
    - Response: ignored; exactly one done per accepted start.
  - Hold start high with A=B=0x4000.
    - Response: done pulses every 6 cycles with cnt_a=cnt_b=1 each time.
- Cap safety: force a_msb=0 and a_zero=0 permanently, with B=0x8000.
  - Response: shift_a stops at cnt_a=15, the FSM reaches STORE, and done asserts at cycle 19.
